// File: rtl/sha256_pkg.sv
// ============================================================================
// sha256_pkg : shared constants and padder state encoding for the SHA-256 front end
// Rev 1.0
// ============================================================================
`default_nettype none

package sha256_pkg;

    localparam int         WORDS_PER_BLOCK = 16;
    localparam int         LEN_HI_IDX      = 14;
    localparam int         LEN_LO_IDX      = 15;
    localparam logic [7:0] PAD_BYTE        = 8'h80;

    typedef enum logic [1:0] {
        ST_DATA   = 2'd0,
        ST_PAD    = 2'd1,
        ST_LEN_HI = 2'd2,
        ST_LEN_LO = 2'd3
    } pad_state_t;

endpackage

`default_nettype wire

// File: rtl/sha256_word_packer.sv
// ============================================================================
// sha256_word_packer : big-endian byte-to-word packer with 0x80 pad insertion
// Rev 1.0
// ============================================================================
`default_nettype none

module sha256_word_packer
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  i_byte,
    input  logic        i_accept,
    input  logic        i_last,
    input  logic        i_issue,
    output logic        o_word_valid,
    output logic [31:0] o_word,
    output logic        o_word_has_pad,
    output logic        o_hold
);

    logic [31:0] r_acc;
    logic [1:0]  r_cnt;
    logic [31:0] r_word;
    logic        r_full;
    logic        r_full_pad;
    logic        r_pad_req;

    logic        w_complete;
    logic        w_tail_pad;
    logic [31:0] w_new_word;

    assign w_complete = i_accept && ((r_cnt == 2'd3) || i_last);
    assign w_tail_pad = i_last && (r_cnt != 2'd3);

    always_comb begin
        w_new_word = r_acc;
        case (r_cnt)
            2'd0: begin
                w_new_word[31:24] = i_byte;
                if (w_tail_pad) w_new_word[23:16] = PAD_BYTE;
            end
            2'd1: begin
                w_new_word[23:16] = i_byte;
                if (w_tail_pad) w_new_word[15:8] = PAD_BYTE;
            end
            2'd2: begin
                w_new_word[15:8] = i_byte;
                if (w_tail_pad) w_new_word[7:0] = PAD_BYTE;
            end
            default: w_new_word[7:0] = i_byte;
        endcase
    end

    // A held word always drains before an owed 0x80000000 word.
    assign o_word_valid   = r_full || r_pad_req || w_complete;
    assign o_word         = r_full ? r_word : (r_pad_req ? {PAD_BYTE, 24'h0} : w_new_word);
    assign o_word_has_pad = r_full ? r_full_pad : (r_pad_req ? 1'b1 : w_tail_pad);
    assign o_hold         = r_full || r_pad_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_word     <= '0;
            r_full     <= 1'b0;
            r_full_pad <= 1'b0;
            r_pad_req  <= 1'b0;
        end else begin
            if (i_accept) begin
                if (w_complete) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_new_word;
                    r_cnt <= r_cnt + 2'd1;
                end
            end
            if (i_issue) begin
                if (r_full) r_full <= 1'b0;
                else if (r_pad_req) r_pad_req <= 1'b0;
            end
            if (w_complete && !i_issue) begin
                r_full     <= 1'b1;
                r_word     <= w_new_word;
                r_full_pad <= w_tail_pad;
            end
            if (i_accept && i_last && (r_cnt == 2'd3)) r_pad_req <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sha256_padder.sv
// ============================================================================
// sha256_padder : byte stream to padded 512-bit blocks for the SHA-256 core
// Rev 1.0
// ============================================================================
`default_nettype none

module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        busy,
    output logic [31:0] data,
    output logic        write_enable,
    output logic        first_block,
    output logic        last_block
);

    pad_state_t       r_state;
    pad_state_t       w_state_nxt;
    logic [3:0]       r_widx;
    logic [LEN_W-1:0] r_len;
    logic             r_extra;
    logic             r_first_pend;
    logic             r_started;

    logic             w_accept;
    logic             w_issue;
    logic [31:0]      w_out_word;
    logic             w_first;
    logic             w_last;
    logic             w_word_valid;
    logic [31:0]      w_word;
    logic             w_word_has_pad;
    logic             w_hold;
    logic [63:0]      w_len64;

    assign in_ready = r_started && (r_state == ST_DATA) && !w_hold;
    assign w_accept = in_valid && in_ready;
    assign w_len64  = 64'(r_len);

    sha256_word_packer u_packer (
        .clk            (clk),
        .reset          (reset),
        .i_byte         (in_data),
        .i_accept       (w_accept),
        .i_last         (in_last),
        .i_issue        (w_issue && (r_state == ST_DATA)),
        .o_word_valid   (w_word_valid),
        .o_word         (w_word),
        .o_word_has_pad (w_word_has_pad),
        .o_hold         (w_hold)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_DATA;
        else        r_state <= w_state_nxt;
    end

    // r_extra marks a 0x80 landing in word 14: word 15 and a whole zero block follow.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_DATA:   if (w_issue && w_word_has_pad)
                           w_state_nxt = (r_widx == 4'(LEN_HI_IDX - 1)) ? ST_LEN_HI : ST_PAD;
            ST_PAD:    if (w_issue && (r_widx == 4'(LEN_HI_IDX - 1)) && !r_extra)
                           w_state_nxt = ST_LEN_HI;
            ST_LEN_HI: if (w_issue) w_state_nxt = ST_LEN_LO;
            ST_LEN_LO: if (w_issue) w_state_nxt = ST_DATA;
            default:   w_state_nxt = ST_DATA;
        endcase
    end

    always_comb begin
        w_issue    = 1'b0;
        w_out_word = '0;
        w_first    = 1'b0;
        w_last     = 1'b0;
        case (r_state)
            ST_DATA: begin
                w_issue    = w_word_valid && !busy;
                w_out_word = w_word;
                w_first    = r_first_pend && (r_widx == 4'd0);
            end
            ST_PAD:    w_issue = !busy;
            ST_LEN_HI: begin
                w_issue    = !busy;
                w_out_word = w_len64[63:32];
            end
            ST_LEN_LO: begin
                w_issue    = !busy;
                w_out_word = w_len64[31:0];
                w_last     = 1'b1;
            end
            default: w_issue = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_widx       <= '0;
            r_len        <= '0;
            r_extra      <= 1'b0;
            r_first_pend <= 1'b1;
            r_started    <= 1'b0;
            data         <= '0;
            write_enable <= 1'b0;
            first_block  <= 1'b0;
            last_block   <= 1'b0;
        end else begin
            r_started <= 1'b1;
            if (w_accept) r_len <= r_len + LEN_W'(8);
            if (w_issue) begin
                r_widx <= r_widx + 4'd1;
                data   <= w_out_word;
            end
            if (w_issue && (r_state == ST_DATA) && w_word_has_pad && (r_widx == 4'(LEN_HI_IDX)))
                r_extra <= 1'b1;
            if (w_issue && (r_state == ST_PAD) && (r_widx == 4'(LEN_LO_IDX)))
                r_extra <= 1'b0;
            if (w_issue && w_first) r_first_pend <= 1'b0;
            if (w_issue && (r_state == ST_LEN_LO)) begin
                r_len        <= '0;
                r_first_pend <= 1'b1;
            end
            write_enable <= w_issue;
            first_block  <= w_issue && w_first;
            last_block   <= w_issue && w_last;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sha256_padder.sv
// ============================================================================
// tb_sha256_padder : randomized self-checking bench against a padded-message model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sha256_padder;

    typedef struct packed {
        logic [31:0] w;
        logic        f;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        busy = 1'b0;
    logic [31:0] data;
    logic        write_enable;
    logic        first_block;
    logic        last_block;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        exp_q[$];
    logic [7:0]  msg_q[$];
    bit          rand_busy = 1'b0;
    bit          use_gaps  = 1'b0;
    bit          stall_armed = 1'b0;
    int          strobe_cnt = 0;
    int          stall_cnt = 0;
    logic        busy_q;

    always #5 clk = ~clk;

    sha256_padder #(.LEN_W(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .busy         (busy),
        .data         (data),
        .write_enable (write_enable),
        .first_block  (first_block),
        .last_block   (last_block)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: message || 0x80 || zeros to 56 mod 64 || 64-bit big-endian bit length.
    function automatic void build_exp();
        logic [7:0]      p[$];
        longint unsigned bitlen;
        int              nw;
        exp_t            e;
        p = msg_q;
        bitlen = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bitlen >> (8 * i)));
        nw = p.size() / 4;
        for (int w = 0; w < nw; w++) begin
            e.w = {p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]};
            e.f = (w == 0);
            e.l = (w == nw - 1);
            exp_q.push_back(e);
        end
    endfunction

    always @(posedge clk) begin
        exp_t e;
        busy_q = busy;
        #1;
        if (write_enable) begin
            chk("we_while_busy", 64'(busy_q), 64'd0);
            chk("word_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("data", 64'(data), 64'(e.w));
                chk("first_block", 64'(first_block), 64'(e.f));
                chk("last_block", 64'(last_block), 64'(e.l));
            end
            if (stall_armed) begin
                strobe_cnt++;
                if (strobe_cnt == 16) begin
                    stall_cnt   = 20;
                    stall_armed = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (stall_cnt > 0) begin
            if (stall_cnt == 1) chk("stall_in_ready", 64'(in_ready), 64'd0);
            busy = 1'b1;
            stall_cnt--;
        end else begin
            busy = rand_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    end

    task automatic send_bytes(input bit with_last);
        bit acc;
        int t;
        for (int i = 0; i < msg_q.size(); i++) begin
            if (use_gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = msg_q[i];
            in_last  = with_last && (i == msg_q.size() - 1);
            t = 0;
            do begin
                acc = in_ready;
                @(negedge clk);
                t++;
            end while (!acc && t < 2000);
            if (!acc) begin
                chk("accept_timeout", 64'(acc), 64'd1);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic rand_msg(input int len);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
    endtask

    task automatic run_msg();
        build_exp();
        send_bytes(1'b1);
        drain();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"}, 64'(data), 64'd0);
        chk({tag, "_we"}, 64'(write_enable), 64'd0);
        chk({tag, "_first"}, 64'(first_block), 64'd0);
        chk({tag, "_last"}, 64'(last_block), 64'd0);
        chk({tag, "_ready"}, 64'(in_ready), 64'd0);
    endtask

    initial begin
        exp_t e;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        chk("ready_before_edge", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("ready_after_edge", 64'(in_ready), 64'd1);

        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg();
        rand_msg(55);  run_msg();
        rand_msg(56);  run_msg();
        rand_msg(64);  run_msg();

        rand_msg(100);
        strobe_cnt  = 0;
        stall_armed = 1'b1;
        run_msg();

        // Abandoned message: only its two completed words are seen before reset.
        rand_msg(10);
        for (int w = 0; w < 2; w++) begin
            e.w = {msg_q[4*w], msg_q[4*w+1], msg_q[4*w+2], msg_q[4*w+3]};
            e.f = (w == 0);
            e.l = 1'b0;
            exp_q.push_back(e);
        end
        send_bytes(1'b0);
        repeat (2) @(negedge clk);
        chk("abandon_words", 64'(exp_q.size()), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b1;
        @(negedge clk);
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg();

        rand_busy = 1'b1;
        use_gaps  = 1'b1;
        for (int m = 0; m < 16; m++) begin
            rand_msg($urandom_range(1, 140));
            run_msg();
        end
        rand_busy = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sha256_padder.md
# sha256_padder

Message pre-processor sitting directly upstream of the SHA-256 core top. It accepts an arbitrary-length byte stream and packs it big-endian into 32-bit words. It appends FIPS 180-4 padding: 0x80, zero fill, then the 64-bit message bit length. It drives the core's `data`/`write_enable`/`first_block`/`last_block` inputs and honours the core's `busy`.

## Interface
- `LEN_W`, default 64: width of the internal message bit-length counter. The emitted length field is always 64 bits, zero-extended.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_data` input 8: message byte.
- `in_valid` input 1: `in_data` valid.
- `in_last` input 1: qualifies the final byte of a message. Messages are at least 1 byte.
- `in_ready` output 1: byte accepted when `in_valid && in_ready` at a clock edge.
- `busy` input 1: from the core. High means the core is compressing and no word may be issued.
- `data` output 32: word to the core.
- `write_enable` output 1: `data` valid this cycle. Issued only when `busy==0`.
- `first_block` output 1: high with word 0 of the first block of a message.
- `last_block` output 1: high with word 15 of the final block of a message.

## Operation
- States:
  - `ST_DATA`: accept bytes.
  - `ST_PAD`: zero words.
  - `ST_LEN_HI`: length word 14.
  - `ST_LEN_LO`: length word 15.
  - Returns to `ST_DATA` after `ST_LEN_LO`.
- Byte packing: byte 0 of each word goes to `data[31:24]`. A 2-bit byte counter and a 4-bit word index (0..15, wraps) are maintained.
- Bit length counter: increments by 8 per accepted byte and is cleared after `ST_LEN_LO`. Arithmetic is modulo 2^`LEN_W`.
- On the accepted byte with `in_last`:
  - **Word incomplete:** the next byte lane gets 0x80, remaining lanes get 0x00, and the word is issued.
  - **Word completed exactly:** the next word is 0x80000000.
- Let k be the index of the word containing 0x80:
  - k ≤ 13: `ST_PAD` issues zero words k+1..13, then `ST_LEN_HI`.
  - k = 14 or 15: zero words to index 15 (end of block), then a full extra block of zeros for words 0..13, then the length words.
- `ST_LEN_HI` issues length bits 63:32. `ST_LEN_LO` issues bits 31:0 with `last_block=1`.
- `first_block` is set with word 0 of the first block after reset or after a completed message. It is never set on an extra padding block.
- `in_ready` is 0 outside `ST_DATA`. In `ST_DATA` it is 0 while the packed-word register is full and not yet issued.

## Timing
- Reset values: `data=0`, `write_enable=0`, `first_block=0`, `last_block=0`, `in_ready=0`. All counters are 0 and state is `ST_DATA`.
- `in_ready` rises on the first edge after reset release.
- Outputs are registered. A word appears with `write_enable=1` on the cycle after its 4th byte is accepted, provided `busy==0`.
- If `busy==1`, the word is held in the output register and `in_ready` is 0 once 4 bytes are pending. `write_enable` stays 0 until the first cycle with `busy==0`.
- `write_enable` is a one-cycle strobe per word. There are never two strobes for the same word.
- Pad and length words issue back-to-back, one per cycle, while `busy==0`.
- The core may raise `busy` in the cycle after word 15. The padder samples `busy` each cycle before issuing, so word 0 of the next block waits.
- A byte with `in_last` accepted in the same cycle a previous word issues is legal. No byte is lost.
- Reset asserted mid-message abandons the message immediately. There is no partial output after reset release.

## Structure
- Package `sha256_pkg` holds:
  - `WORDS_PER_BLOCK=16`, `LEN_HI_IDX=14`, `LEN_LO_IDX=15`, `PAD_BYTE=8'h80`.
  - The padder state enum.
- One natural sub-module, `sha256_word_packer`: byte-to-word shift register with byte counter and a pad-insert request. The FSM, word index and length counter stay in `sha256_padder`.

## Test plan
- **"abc"** (61 62 63, `in_last` on 63), `busy=0`:
  - 16 words: 0x61626380, 13× 0x00000000, 0x00000000, 0x00000018.
  - `first_block` on word 0, `last_block` on word 15.
- **55-byte message:** single block, `0x80` in the last lane of word 13, word 15 = 0x000001B8.
- **56-byte message:** two blocks.
  - Word 14 of block 1 = 0x80000000, word 15 = 0.
  - Block 2 is zeros with word 15 = 0x000001C0, `first_block` only on block 1 word 0, `last_block` only on block 2 word 15.
- **64-byte message:** block 2 word 0 = 0x80000000, block 2 word 15 = 0x00000200.
- **Busy stall:** hold `busy=1` for 20 cycles after word 15 of block 1 of a 100-byte message.
  - No `write_enable` while `busy=1`, and `in_ready` drops.
  - Word sequence is identical to the `busy=0` run.
- **Reset mid-message:** assert `reset` low after 10 bytes of message A, release, then send "abc".
  - All outputs are 0 during reset.
  - Output matches the "abc" case exactly, with `first_block` set.
